// File: rtl/iot_pkg.sv
// Shared definitions for the iot_tx record serializer: function codes, record geometry, FSM states.
package iot_pkg;

  localparam int BYTES_PER_REC = 16;
  localparam int REC_W         = BYTES_PER_REC * 8;
  localparam int IDX_W         = $clog2(BYTES_PER_REC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_REC - 1);

  typedef enum logic [2:0] {
    FN_NONE     = 3'd0,
    FN_MAX      = 3'd1,
    FN_MIN      = 3'd2,
    FN_AVG      = 3'd3,
    FN_EXTRACT  = 3'd4,
    FN_EXCLUDE  = 3'd5,
    FN_PEAK_MAX = 3'd6,
    FN_PEAK_MIN = 3'd7
  } fn_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/iot_tx_if.sv
// Upstream record stream: valid/ready handshake carrying one 128-bit record.
interface iot_tx_if;
  import iot_pkg::*;

  logic             rec_valid;
  logic [REC_W-1:0] rec_data;
  logic             rec_ready;

  modport master (output rec_valid, rec_data, input rec_ready);
  modport slave  (input rec_valid, rec_data, output rec_ready);
endinterface

// File: rtl/iot_tx_ser.sv
// Byte serializer: pulls a record from the hold register and issues bytes 15..0, stalling on busy.
module iot_tx_ser
  import iot_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             busy,
  input  logic             hold_full,
  input  logic [REC_W-1:0] hold_data,
  output logic             take,
  output logic             issue,
  output logic [IDX_W-1:0] idx,
  output logic             in_en,
  output logic [7:0]       iot_in
);

  state_e           state, state_n;
  logic [REC_W-1:0] shf;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Reloading on the byte-0 edge keeps consecutive records gap-free.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    issue   = 1'b0;
    case (state)
      ST_IDLE: if (hold_full && !busy) begin
        state_n = ST_SEND;
        take    = 1'b1;
      end
      ST_SEND: if (!busy) begin
        issue = 1'b1;
        if (idx == '0) begin
          if (hold_full) take    = 1'b1;
          else           state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shf    <= '0;
      idx    <= LAST_IDX;
      in_en  <= 1'b0;
      iot_in <= '0;
    end else begin
      in_en <= issue;
      if (issue) begin
        iot_in <= shf[REC_W-1 -: 8];
        shf    <= shf << 8;
        idx    <= idx - 1'b1;
      end
      if (take) begin
        shf <= hold_data;
        idx <= LAST_IDX;
      end
    end
  end

endmodule

// File: rtl/iot_tx.sv
// Record-to-byte transmitter for the IoT processor: hold register, frame counter, result capture.
// Optional IOT_TX_ERR_EN enables a sticky error on results arriving with no completed frame outstanding.
module iot_tx
  import iot_pkg::*;
#(
  parameter int RECS_PER_FRAME = 8
) (
  input  logic             clk,
  input  logic             rst,
  iot_tx_if.slave          rec,
  input  logic [2:0]       fn_cfg,
  input  logic             busy,
  output logic             in_en,
  output logic [7:0]       iot_in,
  output logic [2:0]       fn_sel,
  input  logic             valid,
  input  logic [REC_W-1:0] iot_out,
  output logic             res_valid,
  output logic [REC_W-1:0] res_data,
  output logic             err
);

  localparam int CNT_W = (RECS_PER_FRAME > 1) ? $clog2(RECS_PER_FRAME) : 1;

  logic             hold_full;
  logic [REC_W-1:0] hold_data;
  logic             take, issue;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] rec_cnt;
  logic             last_rec;

  assign rec.rec_ready = ~hold_full & ~rst;
  assign last_rec      = (rec_cnt == CNT_W'(RECS_PER_FRAME - 1));

  iot_tx_ser u_ser (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .hold_full (hold_full),
    .hold_data (hold_data),
    .take      (take),
    .issue     (issue),
    .idx       (idx),
    .in_en     (in_en),
    .iot_in    (iot_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      rec_cnt   <= '0;
      fn_sel    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (take) hold_full <= 1'b0;
      else if (rec.rec_valid && rec.rec_ready) begin
        hold_full <= 1'b1;
        hold_data <= rec.rec_data;
      end
      // Function is frozen for the frame once record 0 starts going out.
      if (issue && idx == LAST_IDX && rec_cnt == '0) fn_sel <= fn_cfg;
      if (issue && idx == '0) rec_cnt <= last_rec ? '0 : rec_cnt + 1'b1;
      res_valid <= valid;
      if (valid) res_data <= iot_out;
    end
  end

`ifdef IOT_TX_ERR_EN
  logic        frame_done;
  logic [15:0] pend;
  logic        err_q;

  assign frame_done = issue && (idx == '0) && last_rec;
  assign err        = err_q;

  // A frame finishing on the same edge as a result counts as outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= '0;
      err_q <= 1'b0;
    end else begin
      if (valid && pend == '0 && !frame_done) err_q <= 1'b1;
      pend <= pend + 16'(frame_done) - 16'(valid && (pend != '0 || frame_done));
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_iot_tx.sv
// Scoreboard bench for iot_tx: expected bytes queued at record acceptance, checked against a byte monitor.
module tb_iot_tx;
  import iot_pkg::*;

  localparam int RECS = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   fn_cfg;
  logic         busy, in_en, valid, res_valid, err;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic [127:0] iot_out, res_data;

  iot_tx_if rif();

  iot_tx #(.RECS_PER_FRAME(RECS)) dut (
    .clk(clk), .rst(rst), .rec(rif), .fn_cfg(fn_cfg), .busy(busy),
    .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel), .valid(valid),
    .iot_out(iot_out), .res_valid(res_valid), .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; logic [2:0] fs; int cyc; } obs_t;
  typedef struct { logic [7:0] b; logic [2:0] fs; } exp_t;

  obs_t       obs_q[$];
  exp_t       exp_q[$];
  int         cyc = 0;
  int         rd = 0;
  int         n_cmp = 0, n_err = 0;
  int         m_cnt = 0;
  logic [2:0] m_fn = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t o;
    if (in_en === 1'b1) begin
      o.b = iot_in; o.fs = fn_sel; o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  task automatic do_reset();
    rst = 1'b1; rif.rec_valid = 1'b0; valid = 1'b0; busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    m_cnt = 0; exp_q.delete(); rd = obs_q.size();
  endtask

  // Offers one record, waits for the handshake and queues its expected bytes.
  task automatic send_rec(input logic [127:0] d, output int acc, output int lows);
    logic r;
    exp_t e;
    rif.rec_valid = 1'b1; rif.rec_data = d; acc = -1; lows = 0;
    for (int i = 0; i < 200; i++) begin
      r = rif.rec_ready;
      @(negedge clk);
      if (r) begin acc = cyc; break; end
      lows++;
    end
    if (acc >= 0) begin
      if (m_cnt == 0) m_fn = fn_cfg;
      for (int k = 15; k >= 0; k--) begin
        e.b = d[k*8 +: 8]; e.fs = m_fn;
        exp_q.push_back(e);
      end
      m_cnt = (m_cnt + 1) % RECS;
    end
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() - rd >= n) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fn_cfg = 3'd0; busy = 1'b0; iot_out = {4{32'hDEADBEEF}};
    rif.rec_valid = 1'b1; rif.rec_data = {4{32'h12345678}}; valid = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rif.rec_ready !== 1'b0) begin n_err++; $display("FAIL reset rec_ready got %b want 0", rif.rec_ready); end
    n_cmp++; if (in_en !== 1'b0) begin n_err++; $display("FAIL reset in_en got %b want 0", in_en); end
    n_cmp++; if (iot_in !== 8'h00) begin n_err++; $display("FAIL reset iot_in got %h want 00", iot_in); end
    n_cmp++; if (fn_sel !== 3'd0) begin n_err++; $display("FAIL reset fn_sel got %0d want 0", fn_sel); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset res_valid got %b want 0", res_valid); end
    n_cmp++; if (res_data !== '0) begin n_err++; $display("FAIL reset res_data got %h want 0", res_data); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset err got %b want 0", err); end
    rst = 1'b0; rif.rec_valid = 1'b0; valid = 1'b0;
    #1;
    n_cmp++; if (rif.rec_ready !== 1'b1) begin n_err++; $display("FAIL post-reset rec_ready got %b want 1", rif.rec_ready); end
    repeat (4) @(negedge clk);
    n_cmp++; if (in_en !== 1'b0) begin n_err++; $display("FAIL reset-edge record leaked in_en got %b want 0", in_en); end
  endtask

  task automatic test_single();
    int acc, lows; bit ok;
    do_reset(); fn_cfg = 3'd1;
    send_rec(128'h0F0E0D0C0B0A09080706050403020100, acc, lows);
    rif.rec_valid = 1'b0;
    wait_obs(16, 40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single timeout got %0d bytes want 16", obs_q.size() - rd); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (obs_q[rd+i].b !== exp_q[i].b || obs_q[rd+i].fs !== exp_q[i].fs || obs_q[rd+i].cyc !== acc + 2 + i) begin
          n_err++;
          $display("FAIL single byte %0d got %h fn %0d cyc %0d want %h fn %0d cyc %0d", i, obs_q[rd+i].b,
                   obs_q[rd+i].fs, obs_q[rd+i].cyc, exp_q[i].b, exp_q[i].fs, acc + 2 + i);
        end
      end
      repeat (5) @(negedge clk);
      n_cmp++; if (obs_q.size() - rd !== 16) begin n_err++; $display("FAIL single extra bytes got %0d want 16", obs_q.size() - rd); end
    end
  endtask

  task automatic test_back_to_back();
    int acc, acc0, lows, lows_tot; bit ok; int gaps;
    do_reset(); fn_cfg = 3'd1; lows_tot = 0; acc0 = 0;
    for (int r = 0; r < 8; r++) begin
      send_rec({$urandom, $urandom, $urandom, $urandom}, acc, lows);
      if (r == 0) acc0 = acc;
      lows_tot += lows;
    end
    rif.rec_valid = 1'b0;
    wait_obs(128, 300, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL b2b timeout got %0d bytes want 128", obs_q.size() - rd); end
    else begin
      gaps = 0;
      for (int i = 0; i < 128; i++) begin
        n_cmp++;
        if (obs_q[rd+i].b !== exp_q[i].b || obs_q[rd+i].fs !== exp_q[i].fs) begin
          n_err++;
          $display("FAIL b2b byte %0d got %h fn %0d want %h fn %0d", i, obs_q[rd+i].b, obs_q[rd+i].fs, exp_q[i].b, exp_q[i].fs);
        end
        if (obs_q[rd+i].cyc !== acc0 + 2 + i) gaps++;
      end
      n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL b2b contiguity got %0d gaps want 0", gaps); end
    end
    n_cmp++; if (lows_tot == 0) begin n_err++; $display("FAIL b2b rec_ready low cycles got 0 want >0"); end
  endtask

  task automatic test_busy();
    int acc, lows; bit ok;
    do_reset(); fn_cfg = 3'd5;
    send_rec({$urandom, $urandom, $urandom, $urandom}, acc, lows);
    rif.rec_valid = 1'b0;
    while (cyc < acc + 8) @(negedge clk);
    busy = 1'b1;
    while (cyc < acc + 11) @(negedge clk);
    busy = 1'b0;
    wait_obs(16, 40, ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || obs_q.size() - rd !== 16) begin n_err++; $display("FAIL busy byte count got %0d want 16", obs_q.size() - rd); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (obs_q[rd+i].b !== exp_q[i].b || obs_q[rd+i].fs !== exp_q[i].fs) begin
          n_err++;
          $display("FAIL busy byte %0d got %h fn %0d want %h fn %0d", i, obs_q[rd+i].b, obs_q[rd+i].fs, exp_q[i].b, exp_q[i].fs);
        end
      end
      n_cmp++; if (obs_q[rd+6].cyc !== acc + 8) begin n_err++; $display("FAIL busy byte9 cycle got %0d want %0d", obs_q[rd+6].cyc, acc + 8); end
      n_cmp++; if (obs_q[rd+7].cyc !== acc + 12) begin n_err++; $display("FAIL busy byte8 cycle got %0d want %0d", obs_q[rd+7].cyc, acc + 12); end
    end
  endtask

  task automatic test_fn_change();
    int acc, lows; bit ok;
    do_reset(); fn_cfg = 3'd1;
    for (int r = 0; r < 9; r++) begin
      send_rec({$urandom, $urandom, $urandom, $urandom}, acc, lows);
      if (r == 4) fn_cfg = 3'd2;
    end
    rif.rec_valid = 1'b0;
    wait_obs(144, 300, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL fn timeout got %0d bytes want 144", obs_q.size() - rd); end
    else begin
      for (int i = 0; i < 144; i++) begin
        n_cmp++;
        if (obs_q[rd+i].b !== exp_q[i].b || obs_q[rd+i].fs !== exp_q[i].fs) begin
          n_err++;
          $display("FAIL fn byte %0d got %h fn %0d want %h fn %0d", i, obs_q[rd+i].b, obs_q[rd+i].fs, exp_q[i].b, exp_q[i].fs);
        end
      end
      n_cmp++; if (obs_q[rd+128].fs !== 3'd2) begin n_err++; $display("FAIL fn next frame fn_sel got %0d want 2", obs_q[rd+128].fs); end
    end
    // One frame is complete, so a single result is legitimate.
    valid = 1'b1; iot_out = {4{32'h01020304}};
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL fn legit result err got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    int acc, lows; bit ok;
    do_reset(); fn_cfg = 3'd4;
    for (int r = 0; r < 3; r++) send_rec({$urandom, $urandom, $urandom, $urandom}, acc, lows);
    rif.rec_valid = 1'b0;
    wait_obs(43, 120, ok);
    rst = 1'b1;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstmid timeout got %0d bytes want 43", obs_q.size() - rd); end
    else begin
      n_cmp++;
      if (obs_q[rd+42].b !== exp_q[42].b) begin n_err++; $display("FAIL rstmid byte5 got %h want %h", obs_q[rd+42].b, exp_q[42].b); end
    end
    @(negedge clk);
    n_cmp++; if (in_en !== 1'b0) begin n_err++; $display("FAIL rstmid in_en got %b want 0", in_en); end
    @(negedge clk);
    rst = 1'b0; #1;
    m_cnt = 0; exp_q.delete(); rd = obs_q.size();
    fn_cfg = 3'd6;
    send_rec({$urandom, $urandom, $urandom, $urandom}, acc, lows);
    rif.rec_valid = 1'b0;
    wait_obs(16, 40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstmid restart timeout got %0d bytes want 16", obs_q.size() - rd); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (obs_q[rd+i].b !== exp_q[i].b || obs_q[rd+i].fs !== exp_q[i].fs || obs_q[rd+i].cyc !== acc + 2 + i) begin
          n_err++;
          $display("FAIL rstmid restart byte %0d got %h fn %0d cyc %0d want %h fn %0d cyc %0d", i, obs_q[rd+i].b,
                   obs_q[rd+i].fs, obs_q[rd+i].cyc, exp_q[i].b, exp_q[i].fs, acc + 2 + i);
        end
      end
    end
  endtask

  task automatic test_result();
    logic exp_err;
`ifdef IOT_TX_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL result err before valid got %b want 0", err); end
    valid = 1'b1; iot_out = {16{8'hAA}};
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b1 || res_data !== {16{8'hAA}}) begin n_err++; $display("FAIL result first got %b %h want 1 %h", res_valid, res_data, {16{8'hAA}}); end
    iot_out = {16{8'h55}};
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b1 || res_data !== {16{8'h55}}) begin n_err++; $display("FAIL result second got %b %h want 1 %h", res_valid, res_data, {16{8'h55}}); end
    valid = 1'b0; iot_out = '0;
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0 || res_data !== {16{8'h55}}) begin n_err++; $display("FAIL result hold got %b %h want 0 %h", res_valid, res_data, {16{8'h55}}); end
    n_cmp++; if (err !== exp_err) begin n_err++; $display("FAIL result err got %b want %b", err, exp_err); end
    rst = 1'b1; valid = 1'b1; iot_out = {16{8'hCC}};
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0 || res_data !== '0 || err !== 1'b0) begin n_err++; $display("FAIL result during reset got %b %h err %b want 0 0 0", res_valid, res_data, err); end
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy();
    test_fn_change();
    test_reset_mid();
    test_result();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iot_tx.md
IOT_TX -- requirements
Module: iot_tx

Interface
REQ-001 SHALL have parameter RECS_PER_FRAME, default 8: records per frame; fn_sel is constant within a frame.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port rec_valid  in  1  upstream 128-bit record offered.
REQ-005 SHALL have port rec_data  in  128  record; bits [127:120] are byte 15 (first sent), [7:0] byte 0 (last sent).
REQ-006 SHALL have port rec_ready  out  1  record accepted on edge where rec_valid=1 and rec_ready=1.
REQ-007 SHALL have port fn_cfg  in  3  requested function (1 MAX,2 MIN,3 AVG,4 EXTRACT,5 EXCLUDE,6 PEAK_MAX,7 PEAK_MIN).
REQ-008 SHALL have port busy  in  1  processor stall request.
REQ-009 SHALL have port in_en  out  1  byte strobe to processor.
REQ-010 SHALL have port iot_in  out  8  byte to processor.
REQ-011 SHALL have port fn_sel  out  3  function to processor.
REQ-012 SHALL have port valid  in  1  processor result strobe.
REQ-013 SHALL have port iot_out  in  128  processor result.
REQ-014 SHALL have port res_valid  out  1  one-cycle pulse, captured result available.
REQ-015 SHALL have port res_data  out  128  captured result.
REQ-016 SHALL have port err  out  1  sticky protocol error flag (see Configuration).

Function
REQ-017 SHALL hold one record in a hold register; rec_ready = hold empty and rst=0 (registered, no combinational path from busy).
REQ-018 SHALL use states IDLE, SEND; IDLE->SEND at edge where hold full and busy=0, loading shifter from hold and issuing byte 15; SEND->IDLE after byte 0 issued if hold empty.
REQ-019 SHALL, at each SEND edge with busy=0, issue next byte: in_en<=1, iot_in<=byte, byte index decrements 15..0.
REQ-020 SHALL, at any edge with busy=1, drive in_en<=0 and hold byte index, shifter and iot_in contents.
REQ-021 SHALL, when byte 0 is issued and hold is full, load next record and issue its byte 15 on the next non-busy edge with no bubble.
REQ-022 SHALL give latency: record accepted at edge N with shifter idle and busy=0 -> in_en=1, iot_in=byte 15 after edge N+2; byte k after edge N+17-k.
REQ-023 SHALL count records 0..RECS_PER_FRAME-1, wrapping to 0 after last record's byte 0.
REQ-024 SHALL latch fn_sel<=fn_cfg only when issuing byte 15 of record 0; fn_cfg changes mid-frame ignored; undefined value 0 forwarded unchanged.
REQ-025 SHALL, on edge where valid=1, set res_data<=iot_out and res_valid<=1 for one cycle, independent of SEND state; back-to-back valid yields back-to-back pulses.
REQ-026 SHALL drive in_en=0 in IDLE; iot_in holds last value.

Reset
REQ-027 SHALL, on edge with rst=1, clear state to IDLE, hold/shifter empty, byte index 15, record count 0, in_en/iot_in/fn_sel/res_valid/res_data/err to 0; partial frame discarded.
REQ-028 SHALL ignore rec_valid and valid on reset edges.

Configuration
REQ-029 SHALL, with macro IOT_TX_ERR_EN defined, count completed frames minus results and set err sticky when valid=1 with zero frames outstanding; cleared only by rst.
REQ-030 SHALL, without IOT_TX_ERR_EN, tie err to 0 and omit the counter.

Structure
REQ-031 SHALL place fn_sel encodings, BYTES_PER_REC=16 and state encoding in shared package iot_pkg.
REQ-032 SHALL implement shifter and byte index in sub-module iot_tx_ser; frame counter, hold register, result capture in iot_tx.

Verification
REQ-033 SHALL cover: one record 0x0F0E..00, busy=0 -> iot_in 0x0F..0x00 on 16 consecutive in_en cycles, starting 2 cycles after accept.
REQ-034 SHALL cover: 8 back-to-back records, fn_cfg=1 -> 128 contiguous in_en cycles, fn_sel=1 throughout, rec_ready drops while hold full.
REQ-035 SHALL cover: busy=1 for 3 cycles during byte 9 -> in_en=0 for 3 cycles, byte 8 follows, no byte lost or repeated.
REQ-036 SHALL cover: fn_cfg 1->2 during record 3 -> fn_sel stays 1 until record 0 of next frame, then 2.
REQ-037 SHALL cover: rst at byte 5 of record 2 -> in_en=0 next cycle, next record restarts at record count 0, byte 15.
REQ-038 SHALL cover: valid with iot_out=0xAA..AA -> res_valid one cycle, res_data=0xAA..AA; with IOT_TX_ERR_EN and no frame done -> err=1.
